uart_cmd_deframer: RTL

Consumes the byte stream produced by the UART receiver (`data`/`done`/`framing_error`) and assembles fixed-length command packets: a sync byte, `PAYLOAD_BYTES` payload bytes, and an XOR checksum byte. Validated payloads go to the command logic through a one-entry valid/ready output register. Malformed, stale or overflowing packets are dropped, and each drop raises a one-cycle error pulse.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_cmd_deframer_if.sv | 34 +++
 rtl/uart_cmd_deframer_fsm.sv | 98 +++++++++
 rtl/uart_cmd_deframer.sv | 99 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART command deframer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } deframer_state_t;

   localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_deframer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_deframer_if
//  Description : Receiver byte stream in, command valid/ready and error strobes out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_deframer_if #(
   parameter int PAYLOAD_BYTES = 2
);
   logic [7:0]                 rx_data;
   logic                       rx_done;
   logic                       rx_framing_error;
   logic [8*PAYLOAD_BYTES-1:0] cmd_payload;
   logic                       cmd_valid;
   logic                       cmd_ready;
   logic                       err_checksum;
   logic                       err_framing;
   logic                       err_timeout;
   logic                       err_overrun;
   logic                       busy;

   modport master (
      output rx_data, rx_done, rx_framing_error, cmd_ready,
      input  cmd_payload, cmd_valid, err_checksum, err_framing,
             err_timeout, err_overrun, busy
   );

   modport slave (
      input  rx_data, rx_done, rx_framing_error, cmd_ready,
      output cmd_payload, cmd_valid, err_checksum, err_framing,
             err_timeout, err_overrun, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_deframer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_deframer_fsm
//  Description : Packet state machine; emits datapath strobes and registered errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_deframer_fsm
   import uart_pkg::*;
(
   input  wire  clock,
   input  wire  reset,
   input  wire  i_byte,
   input  wire  i_is_sync,
   input  wire  i_fe_rise,
   input  wire  i_idx_last,
   input  wire  i_sum_ok,
   input  wire  i_tmo_end,
   input  wire  i_out_valid,
   input  wire  i_out_ready,
   output logic o_busy,
   output logic o_clear,
   output logic o_shift,
   output logic o_load,
   output logic o_err_checksum,
   output logic o_err_framing,
   output logic o_err_timeout,
   output logic o_err_overrun
);
   localparam logic [1:0] c_ST_HUNT    = HUNT;
   localparam logic [1:0] c_ST_PAYLOAD = PAYLOAD;
   localparam logic [1:0] c_ST_CHECK   = CHECK;

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic       w_good;
   logic       w_err_ck;
   logic       w_err_fr;
   logic       w_err_to;
   logic       w_err_ov;

   // Priority: framing edge, then an accepted byte, then timeout.
   always_comb begin
      w_next_state = r_state;
      o_clear      = 1'b0;
      o_shift      = 1'b0;
      w_good       = 1'b0;
      w_err_ck     = 1'b0;
      w_err_fr     = 1'b0;
      w_err_to     = 1'b0;
      if (i_fe_rise) begin
         w_err_fr     = 1'b1;
         w_next_state = c_ST_HUNT;
      end else if (i_byte) begin
         case (r_state)
            c_ST_HUNT: begin
               if (i_is_sync) begin
                  o_clear      = 1'b1;
                  w_next_state = c_ST_PAYLOAD;
               end
            end
            c_ST_PAYLOAD: begin
               o_shift = 1'b1;
               if (i_idx_last) w_next_state = c_ST_CHECK;
            end
            c_ST_CHECK: begin
               w_next_state = c_ST_HUNT;
               w_good       = i_sum_ok;
               w_err_ck     = ~i_sum_ok;
            end
            default: w_next_state = c_ST_HUNT;
         endcase
      end else if (r_state != c_ST_HUNT && i_tmo_end) begin
         w_err_to     = 1'b1;
         w_next_state = c_ST_HUNT;
      end
   end

   assign o_load   = w_good & (~i_out_valid | i_out_ready);
   assign w_err_ov = w_good & i_out_valid & ~i_out_ready;
   assign o_busy   = (r_state == c_ST_PAYLOAD) || (r_state == c_ST_CHECK);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= c_ST_HUNT;
         o_err_checksum <= 1'b0;
         o_err_framing  <= 1'b0;
         o_err_timeout  <= 1'b0;
         o_err_overrun  <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         o_err_checksum <= w_err_ck;
         o_err_framing  <= w_err_fr;
         o_err_timeout  <= w_err_to;
         o_err_overrun  <= w_err_ov;
      end
   end
endmodule
`default_nettype wire

// File: rtl/uart_cmd_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_deframer
//  Description : Assembles sync/payload/XOR-checksum packets from UART bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_deframer
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = c_SYNC_BYTE_DEFAULT,
   parameter int         PAYLOAD_BYTES  = 2,
   parameter int         TIMEOUT_CYCLES = 25_000
)(
   input wire               clock,
   input wire               reset,
   uart_cmd_deframer_if.slave bus
);
   localparam int c_PAY_W = 8 * PAYLOAD_BYTES;
   localparam int c_IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(PAYLOAD_BYTES - 1);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

   logic [c_PAY_W-1:0] r_asm;
   logic [c_PAY_W-1:0] r_payload;
   logic               r_valid;
   logic [7:0]         r_acc;
   logic [c_IDX_W-1:0] r_idx;
   logic [c_TMO_W-1:0] r_tmo;
   logic               r_fe_prev;

   logic w_byte, w_fe_rise, w_tmo_end;
   logic w_busy, w_clear, w_shift, w_load;

   // Bytes arriving during framing-error recovery are not trustworthy.
   assign w_byte    = bus.rx_done & ~bus.rx_framing_error;
   assign w_fe_rise = bus.rx_framing_error & ~r_fe_prev;
   assign w_tmo_end = (r_tmo == c_TMO_LAST);

   uart_cmd_deframer_fsm u_fsm (
      .clock          (clock),
      .reset          (reset),
      .i_byte         (w_byte),
      .i_is_sync      (bus.rx_data == SYNC_BYTE),
      .i_fe_rise      (w_fe_rise),
      .i_idx_last     (r_idx == c_IDX_LAST),
      .i_sum_ok       (bus.rx_data == r_acc),
      .i_tmo_end      (w_tmo_end),
      .i_out_valid    (r_valid),
      .i_out_ready    (bus.cmd_ready),
      .o_busy         (w_busy),
      .o_clear        (w_clear),
      .o_shift        (w_shift),
      .o_load         (w_load),
      .o_err_checksum (bus.err_checksum),
      .o_err_framing  (bus.err_framing),
      .o_err_timeout  (bus.err_timeout),
      .o_err_overrun  (bus.err_overrun)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_asm     <= '0;
         r_acc     <= '0;
         r_idx     <= '0;
         r_tmo     <= '0;
         r_fe_prev <= 1'b0;
         r_payload <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_fe_prev <= bus.rx_framing_error;
         if (w_clear) begin
            r_asm <= '0;
            r_acc <= '0;
            r_idx <= '0;
         end else if (w_shift) begin
            r_asm <= (r_asm << 8) | c_PAY_W'(bus.rx_data);
            r_acc <= r_acc ^ bus.rx_data;
            r_idx <= r_idx + c_IDX_W'(1);
         end
         // Counts idle cycles within a packet and parks at the terminal value.
         if (!w_busy || w_byte)
            r_tmo <= '0;
         else if (!w_tmo_end)
            r_tmo <= r_tmo + c_TMO_W'(1);
         if (w_load) begin
            r_payload <= r_asm;
            r_valid   <= 1'b1;
         end else if (r_valid && bus.cmd_ready) begin
            r_valid   <= 1'b0;
         end
      end
   end

   assign bus.cmd_payload = r_payload;
   assign bus.cmd_valid   = r_valid;
   assign bus.busy        = w_busy;
endmodule
`default_nettype wire
